// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package imem_fetch_responder_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One response-queue entry
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        addr;
        logic               err;
    } rsp_t;

    // Ceiling log2, usable in constant expressions
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch-stage <-> responder request/response handshake bundle.
interface imem_fetch_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

endinterface

// File: rtl/imem_fetch_responder_rsp_fifo.sv
// In-order response queue with synchronous clear; depth must be a power of two.
module imem_fetch_responder_rsp_fifo
    import imem_fetch_responder_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  rsp_t                push_data,
    input  logic                pop,
    input  logic                clear,
    output rsp_t                head,
    output logic [clog2(QDEPTH):0] count
);

    localparam int unsigned PTR_W = (clog2(QDEPTH) > 0) ? clog2(QDEPTH) : 1;

    rsp_t             entry_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q;

    // Entry storage; stale contents are masked by the top while the queue is empty
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head  = entry_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: store + load port, fixed-latency read pipeline,
// credit-limited in-order response queue, and flush.
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned QDEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_fetch_responder_if.slave bus,
    input  logic                 flush,
    input  logic                 load_en,
    input  logic [31:0]          load_addr,
    input  logic [31:0]          load_data
);

    localparam int unsigned AW    = clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = clog2(QDEPTH) + 1;

    logic [INSTR_W-1:0] store [DEPTH_WORDS];
    logic               ready_en_q;
    logic [CNT_W-1:0]   credit_q, credit_d;
    logic [CNT_W-1:0]   fifo_count;
    logic [AW-1:0]      req_idx, load_idx;
    logic               req_err, accept, push, pop, exit_valid;
    rsp_t               entry_in, exit_entry, head;
    logic               unused_load_bits;

    assign req_idx  = bus.req_addr[AW+1:2];
    assign load_idx = load_addr[AW+1:2];
    assign unused_load_bits = ^{load_addr[1:0], load_addr[31:AW+2]};

    // Misaligned, or any address bit above the word index set
    assign req_err = (bus.req_addr[1:0] != 2'b00) || ((bus.req_addr >> (AW + 2)) != 32'd0);

    // Outstanding work counts against credits; a pop only frees a credit next cycle
    assign bus.req_ready = ready_en_q && (credit_q < CNT_W'(QDEPTH)) && !flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready && !flush;
    assign push          = exit_valid && !flush;

    // Program-image load; same-cycle fetch of the word sees the old contents
    always_ff @(posedge clk) begin
        if (load_en) begin
            store[load_idx] <= load_data;
        end
    end

    // Entry formed at accept; errored fetches return a NOP instead of store data
    always_comb begin
        entry_in.addr  = bus.req_addr;
        entry_in.err   = req_err;
        entry_in.instr = req_err ? NOP_INSTR : store[req_idx];
    end

    if (LATENCY == 1) begin : g_direct
        assign exit_valid = accept;
        assign exit_entry = entry_in;
    end else begin : g_pipe
        logic [LATENCY-2:0] vld_q;
        rsp_t               data_q [LATENCY-1];

        // Shift pipeline; the queue write is the final latency stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int unsigned i = 0; i < LATENCY - 1; i++) data_q[i] <= '0;
            end else begin
                vld_q[0]  <= accept && !flush;
                data_q[0] <= entry_in;
                for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                    vld_q[i]  <= vld_q[i-1] && !flush;
                    data_q[i] <= data_q[i-1];
                end
            end
        end

        assign exit_valid = vld_q[LATENCY-2];
        assign exit_entry = data_q[LATENCY-2];
    end

    imem_fetch_responder_rsp_fifo #(
        .QDEPTH (QDEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (exit_entry),
        .pop       (pop),
        .clear     (flush),
        .head      (head),
        .count     (fifo_count)
    );

    // Outputs read zero whenever nothing is queued
    assign bus.rsp_valid = (fifo_count != '0);
    assign bus.rsp_instr = bus.rsp_valid ? head.instr : NOP_INSTR;
    assign bus.rsp_addr  = bus.rsp_valid ? head.addr : 32'd0;
    assign bus.rsp_err   = bus.rsp_valid && head.err;

    // Credit next-state: flush discards everything in flight
    always_comb begin
        credit_d = credit_q;
        if (flush) begin
            credit_d = '0;
        end else begin
            credit_d = credit_q + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    // Credit register and post-reset ready enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q   <= '0;
            ready_en_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed self-checking bench for imem_fetch_responder (DEPTH 1024, LATENCY 2, QDEPTH 4).
module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'd0;
    logic [31:0] load_data = 32'd0;
    int          n_checks = 0;
    int          n_errors = 0;

    imem_fetch_responder_if bus ();

    imem_fetch_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (2),
        .QDEPTH      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Single fetch with exact-latency check; optional same-cycle load to the same word
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_i,
                         input logic exp_e, input logic with_ld, input logic [31:0] ld_d);
        int budget;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        #1;
        budget = 0;
        while (!bus.req_ready && budget < 20) begin
            @(negedge clk);
            #1;
            budget++;
        end
        check({tag, " accept"}, 32'(bus.req_ready), 32'd1);
        if (with_ld) begin
            load_en   = 1'b1;
            load_addr = a;
            load_data = ld_d;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        load_en       = 1'b0;
        #1;
        check({tag, " early"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check({tag, " valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, " instr"}, bus.rsp_instr, exp_i);
        check({tag, " addr"}, bus.rsp_addr, a);
        check({tag, " err"}, 32'(bus.rsp_err), 32'(exp_e));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_d;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'd0;
        bus.rsp_ready = 1'b0;

        // 1: reset state, release, single fetch
        repeat (2) @(negedge clk);
        #1;
        check("rst ready", 32'(bus.req_ready), 32'd0);
        check("rst valid", 32'(bus.rsp_valid), 32'd0);
        check("rst instr", bus.rsp_instr, 32'd0);
        check("rst addr", bus.rsp_addr, 32'd0);
        check("rst err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release ready pre-edge", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("release ready", 32'(bus.req_ready), 32'd1);
        do_load(32'h10, 32'h2002_0005);
        fetch("t1", 32'h10, 32'h2002_0005, 1'b0, 1'b0, 32'd0);

        // 2: credit limit with backpressure, then in-order drain
        for (int i = 0; i < 4; i++) do_load(32'(i * 4), 32'hC0DE_0000 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(i * 4);
            #1;
            check($sformatf("t2 ready%0d", i), 32'(bus.req_ready), 32'(i < 4));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("t2 hold valid%0d", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("t2 hold addr%0d", i), bus.rsp_addr, 32'h0);
            check($sformatf("t2 hold ready%0d", i), 32'(bus.req_ready), 32'd0);
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            bus.rsp_ready = 1'b1;
            if (j == 2) bus.req_valid = 1'b0;
            #1;
            exp_d = (j < 4) ? 32'hC0DE_0000 + 32'(j) : 32'h2002_0005;
            check($sformatf("t2 pop valid%0d", j), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("t2 pop addr%0d", j), bus.rsp_addr, 32'(j * 4));
            check($sformatf("t2 pop instr%0d", j), bus.rsp_instr, exp_d);
            if (j == 0) check("t2 no early credit", 32'(bus.req_ready), 32'd0);
            if (j == 1) check("t2 credit back", 32'(bus.req_ready), 32'd1);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        check("t2 drained", 32'(bus.rsp_valid), 32'd0);

        // 3: misaligned and out-of-range
        fetch("t3 misaligned", 32'h6, 32'h0, 1'b1, 1'b0, 32'd0);
        fetch("t3 range", 32'h1000, 32'h0, 1'b1, 1'b0, 32'd0);

        // 4: flush with three in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(i * 4);
            #1;
            check($sformatf("t4 ready%0d", i), 32'(bus.req_ready), 32'd1);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        flush         = 1'b1;
        #1;
        check("t4 ready in flush", 32'(bus.req_ready), 32'd0);
        check("t4 valid before flush", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        flush         = 1'b0;
        bus.rsp_ready = 1'b0;
        #1;
        check("t4 valid after flush", 32'(bus.rsp_valid), 32'd0);
        check("t4 credits cleared", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("t4 no stale%0d", i), 32'(bus.rsp_valid), 32'd0);
        end
        fetch("t4 after", 32'h4, 32'hC0DE_0001, 1'b0, 1'b0, 32'd0);
        #1;
        check("t4 single", 32'(bus.rsp_valid), 32'd0);

        // 5: load and fetch of the same word in one cycle
        do_load(32'h8, 32'h1111_1111);
        fetch("t5 old", 32'h8, 32'h1111_1111, 1'b0, 1'b1, 32'hAAAA_AAAA);
        fetch("t5 new", 32'h8, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'd0);

        // 6: reset with a full queue
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(i * 4);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t6 full valid", 32'(bus.rsp_valid), 32'd1);
        check("t6 full ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6 rst valid", 32'(bus.rsp_valid), 32'd0);
        check("t6 rst instr", bus.rsp_instr, 32'd0);
        check("t6 rst addr", bus.rsp_addr, 32'd0);
        check("t6 rst err", 32'(bus.rsp_err), 32'd0);
        check("t6 rst ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("t6 empty after", 32'(bus.rsp_valid), 32'd0);
        check("t6 ready after", 32'(bus.req_ready), 32'd1);
        fetch("t6 fetch", 32'h10, 32'h2002_0005, 1'b0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
